// File: rtl/toggle_cover_collector.sv
// Per-bit rise/fall toggle coverage with a sticky bitmap.
// Newly covered points leave one per transfer on a valid/ready stream.
module toggle_cover_collector #(
  parameter int          WIDTH       = 27,
  parameter int unsigned COVER_INDEX = 0,
  parameter int          INDEX_W     = 32,
  parameter int          CNT_W       = $clog2(2*WIDTH+1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [WIDTH-1:0]   sig,
  input  logic               cover_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] out_index,
  output logic [CNT_W-1:0]   covered_count,
  output logic               all_covered
);

  localparam int NP = 2*WIDTH;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] prev;
  logic             primed;
  logic [NP-1:0]    covered;
  logic [NP-1:0]    pending;
  logic [NP-1:0]    tog;
  logic [NP-1:0]    hit;
  logic [NP-1:0]    new_pts;
  logic [NP-1:0]    avail;
  logic [NP-1:0]    pend_nx;
  logic             slot_free;
  logic             found;
  logic [PW-1:0]    sel;
  logic [CNT_W-1:0] add;

  always_comb begin
    tog = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tog[2*i]   = ~prev[i] & sig[i];
      tog[2*i+1] = prev[i] & ~sig[i];
    end
  end

  assign hit       = tog & {NP{en & primed}};
  assign new_pts   = hit & ~covered;
  // a clear also stops any pending point from being loaded
  assign avail     = cover_clear ? '0 : pending;
  assign slot_free = (state == IDLE) | out_ready;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NP-1; i >= 0; i--) begin
      if (avail[i]) begin
        found = 1'b1;
        sel   = PW'(i);
      end
    end
  end

  always_comb begin
    add = '0;
    for (int i = 0; i < NP; i++) begin
      add = add + CNT_W'(new_pts[i]);
    end
  end

  always_comb begin
    pend_nx = cover_clear ? '0 : (pending | new_pts);
    if (slot_free && found) begin
      pend_nx[sel] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      out_index     <= '0;
      covered_count <= '0;
      covered       <= '0;
      pending       <= '0;
      prev          <= '0;
      primed        <= 1'b0;
    end else begin
      prev    <= sig;
      primed  <= 1'b1;
      pending <= pend_nx;
      if (cover_clear) begin
        covered       <= '0;
        covered_count <= '0;
      end else begin
        covered       <= covered | new_pts;
        covered_count <= covered_count + add;
      end
      if (slot_free) begin
        if (found) begin
          state     <= HOLD;
          out_index <= INDEX_W'(COVER_INDEX) + INDEX_W'(sel);
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  assign out_valid   = (state == HOLD);
  assign all_covered = (covered_count == CNT_W'(NP));

endmodule
